nw_cell_scorer: RTL and testbench
=================================

Name: nw_cell_scorer

Overview:
Needleman-Wunsch score-matrix fill engine for the (N+1)x(N+1) DP matrix held in single-port synchronous score RAM. Sits directly upstream of Insertion_counter:
- drives its en_read / change_index;
- consumes its i, j and end_filling.
For each cell it reads the diagonal, up and left neighbours, computes the max score and writes it back. Also initialises the gap boundaries and exposes the final alignment score.

Parameters:
- N, 2, sequence length (matrix is (N+1)x(N+1)); must match Insertion_counter N
- BitAddr, $clog2(N+1), index width minus one (indices are [BitAddr:0])
- SW, 8, signed score width
- AW, $clog2((N+1)*(N+1)), RAM address width
- MATCH, 1, signed match bonus
- MISMATCH, -1, signed mismatch penalty
- GAP, -1, signed gap penalty

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (low = reset)
- start  in  1  begin fill; sampled only in IDLE
- i  in  BitAddr+1  row index from Insertion_counter
- j  in  BitAddr+1  column index from Insertion_counter
- end_filling  in  1  from Insertion_counter
- char_a  in  2  sequence-A symbol at index i (combinational from sequence ROM)
- char_b  in  2  sequence-B symbol at index j
- en_read  out  1  to Insertion_counter
- change_index  out  1  one-cycle advance pulse to Insertion_counter
- ram_addr  out  AW  RAM address; row*(N+1)+col
- ram_we  out  1  write enable
- ram_wr_data  out  SW  write data
- ram_rd_data  in  SW  read data, valid the cycle after the address is issued
- busy  out  1  high from INIT through FINISH
- done  out  1  level; high in DONE until next accepted start
- final_score  out  SW  score of cell (N,N); valid while done

Behaviour:
- Reset (rst low, async):
  - state IDLE;
  - all outputs 0 (en_read, change_index, ram_we, ram_addr, ram_wr_data, busy, done, final_score);
  - internal registers 0.
  - A reset mid-fill aborts immediately; RAM contents are don't-care.
- IDLE: start=1 -> INIT, busy=1, done=0. Otherwise hold.
- INIT: 2N+1 cycles, one write per cycle (ram_we=1), in this order:
  - (0,0)=0;
  - then (0,c)=c*GAP for c=1..N;
  - then (r,0)=r*GAP for r=1..N.
  - Then go to RD_D.
- Per-cell sequence, for target cell (i+1, j+1):
  - RD_D: ram_addr=(i,j).
  - RD_U: ram_addr=(i,j+1); capture D.
  - RD_L: ram_addr=(i+1,j); capture U.
  - CALC: capture L; compute registered result:
    - diag = D + (char_a==char_b ? MATCH : MISMATCH)
    - up = U + GAP
    - left = L + GAP
    - score = max(diag, up, left); ties prefer diag > up > left.
    - Arithmetic in SW+1 bits, saturated to the signed SW range.
  - WR: ram_we=1, ram_addr=(i+1,j+1), ram_wr_data=score.
  - ADV:
    - if i==N-1 and j==N-1: final_score<=score, go to FINISH, no change_index pulse;
    - else change_index=1 for this cycle only, go to RD_D.
  - 6 cycles per cell.
- en_read: 1 in RD_D..ADV; 0 in IDLE, INIT, FINISH, DONE.
- FINISH: en_read=0; wait for end_filling=1, then go to DONE with busy=0, done=1. Stays in FINISH indefinitely otherwise.
- DONE: hold outputs. start=1 -> INIT (restart; done drops the same edge).
- start is ignored outside IDLE and DONE.
- i and j are used combinationally in RD_D..CALC; they are stable because change_index pulses only in ADV.
- Latency: done rises (2N+1)+6N^2+1 cycles after the start-sampling edge.

Decomposition:
- Shared package nw_pkg:
  - state encoding (IDLE, INIT, RD_D, RD_U, RD_L, CALC, WR, ADV, FINISH, DONE);
  - symbol encoding A=00, C=01, G=10, T=11;
  - default MATCH/MISMATCH/GAP;
  - address-compute function row*(N+1)+col.
- One natural sub-module: nw_max3_sat. Combinational add/saturate/3-way max with tie priority; reused by the traceback block.

Test Plan:
- N=2, A=AC, B=AC, start pulse -> RAM rows [0,-1,-2],[-1,1,0],[-2,0,2]; final_score=2; done high 30 cycles after start edge.
- N=2, A=AA, B=CC -> cells (1,1)=-1, (1,2)=-2, (2,1)=-2, (2,2)=-2 (diag wins ties); final_score=-2.
- change_index: exactly N^2-1 single-cycle pulses, each in ADV; none for the last cell; en_read low in FINISH, after which end_filling rises; i=j=N-1 at done.
- rst driven low during the RD_U of cell (1,2) -> all outputs 0 asynchronously; after release, state IDLE, no RAM writes until a new start.
- Saturation, SW=4, MATCH=7, A=AA, B=AA -> (2,2) would be 14; must write +7 (max); final_score=7.
- start held high throughout -> a single fill; start re-sampled only in DONE, which restarts INIT with done falling on that edge.

Source files
------------

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch fill engine: FSM states,
// symbol codes, default scoring constants and matrix address mapping.
package nw_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_D,
        RD_U,
        RD_L,
        CALC,
        WR,
        ADV,
        FINISH,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SYM_A = 2'b00,
        SYM_C = 2'b01,
        SYM_G = 2'b10,
        SYM_T = 2'b11
    } sym_t;

    // Winning predecessor, consumed by traceback.
    typedef enum logic [1:0] {
        DIR_DIAG = 2'b00,
        DIR_UP   = 2'b01,
        DIR_LEFT = 2'b10
    } dir_t;

    localparam int DEF_MATCH    = 1;
    localparam int DEF_MISMATCH = -1;
    localparam int DEF_GAP      = -1;

    // Row-major linear address of cell (row, col) in an (n+1)x(n+1) matrix.
    function automatic int cell_addr(input int row, input int col, input int n);
        return row * (n + 1) + col;
    endfunction

endpackage

// File: rtl/nw_max3_sat.sv
// Adds a bonus/penalty to each of three neighbour scores with signed
// saturation, then picks the maximum with priority diag > up > left.
module nw_max3_sat
    import nw_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] diag_base,
    input  logic [SW-1:0] diag_add,
    input  logic [SW-1:0] up_base,
    input  logic [SW-1:0] up_add,
    input  logic [SW-1:0] left_base,
    input  logic [SW-1:0] left_add,
    output logic [SW-1:0] score,
    output logic [1:0]    dir
);

    localparam logic [SW-1:0] SAT_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] SAT_MIN = {1'b1, {(SW-1){1'b0}}};

    // One extra bit of headroom; overflow shows as the top two bits differing.
    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {a[SW-1], a} + {b[SW-1], b};
        if (s[SW] != s[SW-1]) begin
            return s[SW] ? SAT_MIN : SAT_MAX;
        end
        return s[SW-1:0];
    endfunction

    logic [SW-1:0] diag_sum;
    logic [SW-1:0] up_sum;
    logic [SW-1:0] left_sum;

    assign diag_sum = sat_add(diag_base, diag_add);
    assign up_sum   = sat_add(up_base, up_add);
    assign left_sum = sat_add(left_base, left_add);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        score = diag_sum;
        dir   = DIR_DIAG;
        // Strict greater-than keeps the earlier candidate on ties.
        if ($signed(up_sum) > $signed(score)) begin
            score = up_sum;
            dir   = DIR_UP;
        end
        if ($signed(left_sum) > $signed(score)) begin
            score = left_sum;
            dir   = DIR_LEFT;
        end
    end

endmodule

// File: rtl/nw_cell_scorer.sv
// Needleman-Wunsch score-matrix fill engine: initialises the gap boundaries,
// then reads D/U/L neighbours, scores and writes back every interior cell.
module nw_cell_scorer
    import nw_pkg::*;
#(
    parameter int N        = 2,
    parameter int BitAddr  = $clog2(N + 1),
    parameter int SW       = 8,
    parameter int AW       = $clog2((N + 1) * (N + 1)),
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int GAP      = DEF_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BitAddr:0]  i,
    input  logic [BitAddr:0]  j,
    input  logic              end_filling,
    input  logic [1:0]        char_a,
    input  logic [1:0]        char_b,
    output logic              en_read,
    output logic              change_index,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [SW-1:0]     ram_wr_data,
    input  logic [SW-1:0]     ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic [SW-1:0]     final_score
);

    localparam int              IW        = BitAddr + 1;
    localparam int              CW        = $clog2(2 * N + 1);
    localparam logic [CW-1:0]   INIT_LAST = CW'(2 * N);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(N - 1);
    localparam logic [SW-1:0]   GAP_ADD   = SW'(GAP);

    function automatic logic [AW-1:0] addr_of(input int row, input int col);
        return AW'(cell_addr(row, col, N));
    endfunction

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] init_cnt;
    logic [SW-1:0] d_reg;
    logic [SW-1:0] u_reg;
    logic [SW-1:0] score_reg;
    logic [SW-1:0] final_q;

    int            init_row;
    int            init_col;
    int            row_i;
    int            col_j;
    logic [SW-1:0] init_val;
    logic [SW-1:0] match_add;
    logic [SW-1:0] cell_score;
    logic          last_cell;

    assign row_i     = int'(i);
    assign col_j     = int'(j);
    assign last_cell = (i == LAST_IDX) && (j == LAST_IDX);
    assign match_add = (char_a == char_b) ? SW'(MATCH) : SW'(MISMATCH);

    // Boundary walk: (0,0), then row 0 left to right, then column 0 top to bottom.
    always_comb begin
        init_row = 0;
        init_col = 0;
        if (int'(init_cnt) <= N) begin
            init_col = int'(init_cnt);
        end else begin
            init_row = int'(init_cnt) - N;
        end
    end

    assign init_val = SW'((init_row + init_col) * GAP);

    // The left neighbour is taken straight off the RAM read port during CALC.
    nw_max3_sat #(
        .SW(SW)
    ) u_max3 (
        .diag_base (d_reg),
        .diag_add  (match_add),
        .up_base   (u_reg),
        .up_add    (GAP_ADD),
        .left_base (ram_rd_data),
        .left_add  (GAP_ADD),
        .score     (cell_score),
        .dir       ()
    );

    always_comb begin
        state_n      = state;
        en_read      = 1'b0;
        change_index = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wr_data  = '0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_n = INIT;
                end
            end
            INIT: begin
                ram_we      = 1'b1;
                ram_addr    = addr_of(init_row, init_col);
                ram_wr_data = init_val;
                if (init_cnt == INIT_LAST) begin
                    state_n = RD_D;
                end
            end
            RD_D: begin
                en_read  = 1'b1;
                ram_addr = addr_of(row_i, col_j);
                state_n  = RD_U;
            end
            RD_U: begin
                en_read  = 1'b1;
                ram_addr = addr_of(row_i, col_j + 1);
                state_n  = RD_L;
            end
            RD_L: begin
                en_read  = 1'b1;
                ram_addr = addr_of(row_i + 1, col_j);
                state_n  = CALC;
            end
            CALC: begin
                en_read = 1'b1;
                state_n = WR;
            end
            WR: begin
                en_read     = 1'b1;
                ram_we      = 1'b1;
                ram_addr    = addr_of(row_i + 1, col_j + 1);
                ram_wr_data = score_reg;
                state_n     = ADV;
            end
            ADV: begin
                en_read = 1'b1;
                if (last_cell) begin
                    state_n = FINISH;
                end else begin
                    change_index = 1'b1;
                    state_n      = RD_D;
                end
            end
            FINISH: begin
                if (end_filling) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    state_n = INIT;
                end
            end
            default: begin
                busy    = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: state is assigned with <= so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            init_cnt  <= '0;
            d_reg     <= '0;
            u_reg     <= '0;
            score_reg <= '0;
            final_q   <= '0;
        end else begin
            state <= state_n;

            if (state == INIT && init_cnt != INIT_LAST) begin
                init_cnt <= init_cnt + CW'(1);
            end else begin
                init_cnt <= '0;
            end

            // Read data arrives one cycle after its address was issued.
            if (state == RD_U) begin
                d_reg <= ram_rd_data;
            end
            if (state == RD_L) begin
                u_reg <= ram_rd_data;
            end
            if (state == CALC) begin
                score_reg <= cell_score;
            end
            if (state == ADV && last_cell) begin
                final_q <= score_reg;
            end
        end
    end

    assign final_score = final_q;

endmodule

// File: tb/tb_nw_cell_scorer.sv
// Bench for nw_cell_scorer: two instances (SW=8/MATCH=1 and SW=4/MATCH=7) with
// a behavioural RAM and index counter; every RAM write is scoreboarded.
module tb_nw_cell_scorer;
    import nw_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic       k;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    logic       start        [2];
    logic [2:0] i_idx        [2];
    logic [2:0] j_idx        [2];
    logic       end_filling  [2];
    logic [1:0] char_a       [2];
    logic [1:0] char_b       [2];
    logic       en_read      [2];
    logic       change_index [2];
    logic [3:0] ram_addr     [2];
    logic       ram_we       [2];
    logic [7:0] wr_data      [2];
    logic [7:0] rd_data      [2];
    logic       busy         [2];
    logic       done         [2];
    logic [7:0] fs           [2];
    logic [7:0] mem          [2][9];
    logic [1:0] seq_a        [2][2];
    logic [1:0] seq_b        [2][2];

    int  checks = 0;
    int  errors = 0;
    int  wr_count    [2] = '{0, 0};
    int  pulse_count [2] = '{0, 0};
    logic prev_wr_cell [2] = '{1'b0, 1'b0};
    logic prev_ci      [2] = '{1'b0, 1'b0};
    wr_t sb_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int SWG = (g == 0) ? 8 : 4;
        localparam int MG  = (g == 0) ? 1 : 7;
        logic [SWG-1:0] wd;
        logic [SWG-1:0] fsg;

        nw_cell_scorer #(
            .N     (N),
            .SW    (SWG),
            .MATCH (MG)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start[g]),
            .i            (i_idx[g]),
            .j            (j_idx[g]),
            .end_filling  (end_filling[g]),
            .char_a       (char_a[g]),
            .char_b       (char_b[g]),
            .en_read      (en_read[g]),
            .change_index (change_index[g]),
            .ram_addr     (ram_addr[g]),
            .ram_we       (ram_we[g]),
            .ram_wr_data  (wd),
            .ram_rd_data  (rd_data[g][SWG-1:0]),
            .busy         (busy[g]),
            .done         (done[g]),
            .final_score  (fsg)
        );

        assign wr_data[g] = 8'($signed(wd));
        assign fs[g]      = 8'($signed(fsg));
    end

    // Sequence ROMs and the Insertion_counter end-of-fill flag.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            char_a[k]      = seq_a[k][i_idx[k][0]];
            char_b[k]      = seq_b[k][j_idx[k][0]];
            end_filling[k] = (i_idx[k] == 3'(N - 1)) && (j_idx[k] == 3'(N - 1)) &&
                             !en_read[k] && !ram_we[k];
        end
    end

    // Synchronous single-port RAM plus the row-major index counter.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                i_idx[k]   <= '0;
                j_idx[k]   <= '0;
                rd_data[k] <= '0;
            end else begin
                rd_data[k] <= mem[k][ram_addr[k]];
                if (ram_we[k]) mem[k][ram_addr[k]] <= wr_data[k];
                if (ram_we[k] && !en_read[k]) begin
                    i_idx[k] <= '0;
                    j_idx[k] <= '0;
                end else if (change_index[k]) begin
                    if (j_idx[k] == 3'(N - 1)) begin
                        j_idx[k] <= '0;
                        i_idx[k] <= i_idx[k] + 3'd1;
                    end else begin
                        j_idx[k] <= j_idx[k] + 3'd1;
                    end
                end
            end
        end
    end

    // Write scoreboard and change_index pulse monitor.
    always @(negedge clk) begin : monitor
        wr_t e;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                prev_wr_cell[k] = 1'b0;
                prev_ci[k]      = 1'b0;
            end else begin
                if (ram_we[k]) begin
                    wr_count[k]++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected inst=%0d got addr=%0d data=%0d required no write",
                                 k, ram_addr[k], $signed(wr_data[k]));
                    end else begin
                        e = sb_q.pop_front();
                        if (e.k !== 1'(k) || ram_addr[k] !== e.a || wr_data[k] !== e.d) begin
                            errors++;
                            $display("FAIL write inst=%0d got addr=%0d data=%0d required inst=%0d addr=%0d data=%0d",
                                     k, ram_addr[k], $signed(wr_data[k]), e.k, e.a, $signed(e.d));
                        end
                    end
                end
                if (change_index[k]) begin
                    pulse_count[k]++;
                    checks++;
                    if (!prev_wr_cell[k] || prev_ci[k]) begin
                        errors++;
                        $display("FAIL change_index_pulse inst=%0d got prev_wr=%0b prev_ci=%0b required 1 0",
                                 k, prev_wr_cell[k], prev_ci[k]);
                    end
                end
                prev_wr_cell[k] = ram_we[k] && en_read[k];
                prev_ci[k]      = change_index[k];
            end
        end
    end

    function automatic int sat(input int v, input int sw);
        int lim;
        lim = 1 << (sw - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Reference NW fill: pushes every expected write of one fill in issue order.
    task automatic push_expected(input int k);
        int sc [3][3];
        int sw, mt, d, u, l, best;
        sw = (k == 0) ? 8 : 4;
        mt = (k == 0) ? 1 : 7;
        sc[0][0] = 0;
        sb_q.push_back('{k: 1'(k), a: 4'(0), d: 8'(0)});
        for (int c = 1; c <= N; c++) begin
            sc[0][c] = -c;
            sb_q.push_back('{k: 1'(k), a: 4'(c), d: 8'(-c)});
        end
        for (int r = 1; r <= N; r++) begin
            sc[r][0] = -r;
            sb_q.push_back('{k: 1'(k), a: 4'(r * (N + 1)), d: 8'(-r)});
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                d = sat(sc[r][c] + ((seq_a[k][r] == seq_b[k][c]) ? mt : -1), sw);
                u = sat(sc[r][c + 1] - 1, sw);
                l = sat(sc[r + 1][c] - 1, sw);
                best = d;
                if (u > best) best = u;
                if (l > best) best = l;
                sc[r + 1][c + 1] = best;
                sb_q.push_back('{k: 1'(k), a: 4'((r + 1) * (N + 1) + c + 1), d: 8'(best)});
            end
        end
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!done[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!done[k]) begin
            errors++;
            $display("FAIL fill_timeout inst=%0d got done=%0b after %0d cycles required 1", k, done[k], lat);
        end
    endtask

    task automatic run_fill(input int k, output int lat);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        wait_done(k, lat);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({en_read[k], change_index[k], ram_we[k], ram_addr[k], wr_data[k],
                 busy[k], done[k], fs[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got we=%0b addr=%0d busy=%0b done=%0b required all 0",
                         k, ram_we[k], ram_addr[k], busy[k], done[k]);
            end
        end
    endtask

    task automatic test_fill_match();
        int lat, base;
        int exp_mem [9] = '{0, -1, -2, -1, 1, 0, -2, 0, 2};
        seq_a[0][0] = SYM_A; seq_a[0][1] = SYM_C;
        seq_b[0][0] = SYM_A; seq_b[0][1] = SYM_C;
        push_expected(0);
        base = pulse_count[0];
        run_fill(0, lat);
        check_int("match_latency", lat, 30);
        check_int("match_final_score", int'($signed(fs[0])), 2);
        check_int("match_sb_empty", sb_q.size(), 0);
        check_int("match_pulses", pulse_count[0] - base, N * N - 1);
        check_int("match_en_read_done", int'(en_read[0]), 0);
        check_int("match_i_at_done", int'(i_idx[0]), N - 1);
        check_int("match_j_at_done", int'(j_idx[0]), N - 1);
        for (int a = 0; a < 9; a++) begin
            check_int($sformatf("match_mem_%0d", a), int'($signed(mem[0][a])), exp_mem[a]);
        end
        repeat (3) @(posedge clk);
        #1;
        check_int("match_done_hold", int'(done[0]), 1);
        check_int("match_busy_in_done", int'(busy[0]), 0);
        check_int("match_final_hold", int'($signed(fs[0])), 2);
    endtask

    task automatic test_fill_mismatch();
        int lat;
        seq_a[0][0] = SYM_A; seq_a[0][1] = SYM_A;
        seq_b[0][0] = SYM_C; seq_b[0][1] = SYM_C;
        push_expected(0);
        run_fill(0, lat);
        check_int("mismatch_latency", lat, 30);
        check_int("mismatch_final_score", int'($signed(fs[0])), -2);
        check_int("mismatch_cell_11", int'($signed(mem[0][4])), -1);
        check_int("mismatch_cell_12", int'($signed(mem[0][5])), -2);
        check_int("mismatch_cell_21", int'($signed(mem[0][7])), -2);
        check_int("mismatch_cell_22", int'($signed(mem[0][8])), -2);
        check_int("mismatch_sb_empty", sb_q.size(), 0);
    endtask

    task automatic test_reset_midfill();
        int base;
        seq_a[0][0] = SYM_A; seq_a[0][1] = SYM_C;
        seq_b[0][0] = SYM_A; seq_b[0][1] = SYM_C;
        push_expected(0);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_int("midfill_en_read", int'(en_read[0]), 1);
        check_int("midfill_rd_u_addr", int'(ram_addr[0]), 2);
        rst = 1'b0;
        #1;
        test_reset();
        check_int("midfill_pending_writes", sb_q.size(), 3);
        sb_q.delete();
        #12;
        rst = 1'b1;
        base = wr_count[0];
        repeat (10) @(posedge clk);
        #1;
        check_int("midfill_no_writes", wr_count[0] - base, 0);
        check_int("midfill_busy_idle", int'(busy[0]), 0);
        check_int("midfill_done_idle", int'(done[0]), 0);
    endtask

    task automatic test_saturation();
        int lat;
        seq_a[1][0] = SYM_A; seq_a[1][1] = SYM_A;
        seq_b[1][0] = SYM_A; seq_b[1][1] = SYM_A;
        push_expected(1);
        run_fill(1, lat);
        check_int("sat_latency", lat, 30);
        check_int("sat_final_score", int'($signed(fs[1])), 7);
        check_int("sat_cell_11", int'($signed(mem[1][4])), 7);
        check_int("sat_cell_22", int'($signed(mem[1][8])), 7);
        check_int("sat_sb_empty", sb_q.size(), 0);
    endtask

    task automatic test_back_to_back();
        int lat;
        seq_a[0][0] = SYM_A; seq_a[0][1] = SYM_C;
        seq_b[0][0] = SYM_A; seq_b[0][1] = SYM_C;
        push_expected(0);
        push_expected(0);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, lat);
        check_int("held_latency", lat, 30);
        @(posedge clk);
        #1;
        check_int("held_restart_done", int'(done[0]), 0);
        check_int("held_restart_busy", int'(busy[0]), 1);
        repeat (8) @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_done(0, lat);
        check_int("held_second_final", int'($signed(fs[0])), 2);
        check_int("held_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        rst      = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            seq_a[k][0] = SYM_A; seq_a[k][1] = SYM_A;
            seq_b[k][0] = SYM_A; seq_b[k][1] = SYM_A;
        end
        #2;
        test_reset();
        #18;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_fill_match();
        test_fill_mismatch();
        test_reset_midfill();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
